// File: rtl/tjmono2_rx_merger_if.sv
// tjmono2_rx_merger_if: bus, lane and readout signals of the rx merger
//  BUS_*     basil 8-bit register bus (address, write/read data, strobes)
//  CH_*      lane FWFT FIFOs: empty flags, head words, pop strobes
//  FIFO_*    readout FIFO view of the merged stream, CUR_CH granted lane
//  master drives the bus and lanes, slave is the merger itself
interface tjmono2_rx_merger_if #(
    parameter int NUM_CH = 4,
    parameter int ABUSWIDTH = 32
);
    logic [ABUSWIDTH-1:0] BUS_ADD;
    logic [7:0] BUS_DATA_IN;
    logic [7:0] BUS_DATA_OUT;
    logic BUS_WR;
    logic BUS_RD;
    logic [NUM_CH-1:0] CH_EMPTY;
    logic [28*NUM_CH-1:0] CH_DATA;
    logic [NUM_CH-1:0] CH_READ;
    logic FIFO_READ;
    logic FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [2:0] CUR_CH;
    modport master (
        output BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD, CH_EMPTY, CH_DATA, FIFO_READ,
        input BUS_DATA_OUT, CH_READ, FIFO_EMPTY, FIFO_DATA, CUR_CH
    );
    modport slave (
        input BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD, CH_EMPTY, CH_DATA, FIFO_READ,
        output BUS_DATA_OUT, CH_READ, FIFO_EMPTY, FIFO_DATA, CUR_CH
    );
endinterface

// File: rtl/tjmono2_rx_merger.sv
// tjmono2_rx_merger: round-robin merge of NUM_CH tjmono2 lanes into one tagged 32-bit stream
//  BUS_CLK    single clock for bus, arbiter and datapath
//  BUS_RST_N  synchronous reset, active low (a bus write to address 0 resets as well)
//  bus        slave view of tjmono2_rx_merger_if: register bus, lane FIFOs, readout register
module tjmono2_rx_merger #(
    parameter int NUM_CH = 4,
    parameter int DATA_IDENTIFIER = 0,
    parameter int ABUSWIDTH = 32
) (
    input logic BUS_CLK,
    input logic BUS_RST_N,
    tjmono2_rx_merger_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;
    localparam logic [7:0] VERSION = 8'd1;
    localparam logic [7:0] EN_MASK = 8'((1 << NUM_CH) - 1);

    logic [0:0] state;
    logic [7:0] en, burst, burst_cnt, burst_eff, ch_empty, rd_mux;
    logic [2:0] cur_ch, next_ch, start, idx;
    logic [3:0] tag;
    logic fresh, found, pop, done, soft_rst, rst, cnt_clr, fifo_empty;
    logic [31:0] fifo_data;
    logic [27:0] ch_word [8];
    logic [15:0] cnt [NUM_CH];
    logic [7:0] hi_buf [NUM_CH];

    assign soft_rst = bus.BUS_WR && bus.BUS_ADD == '0;
    assign rst = !BUS_RST_N || soft_rst;
    assign cnt_clr = bus.BUS_WR && bus.BUS_ADD == ABUSWIDTH'(3);
    assign burst_eff = burst == 8'd0 ? 8'd1 : burst;
    assign tag = 4'(DATA_IDENTIFIER + int'(cur_ch));

    // lanes beyond NUM_CH look permanently empty so 3-bit lane indices stay in range
    always_comb begin
        ch_empty = '1;
        for (int i = 0; i < 8; i++) ch_word[i] = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_empty[i] = bus.CH_EMPTY[i];
            ch_word[i] = bus.CH_DATA[28*i +: 28];
        end
    end

    // round-robin search; the first grant after reset starts at lane 0
    assign start = (fresh || int'(cur_ch) == NUM_CH - 1) ? 3'd0 : cur_ch + 3'd1;

    // scanning downwards lets the lane closest to start win
    always_comb begin
        found = 1'b0;
        next_ch = cur_ch;
        idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = 3'((int'(start) + k) % NUM_CH);
            if (en[idx] && !ch_empty[idx]) begin
                found = 1'b1;
                next_ch = idx;
            end
        end
    end

    assign pop = state == XFER && en[cur_ch] && !ch_empty[cur_ch] && (fifo_empty || bus.FIFO_READ);
    assign done = (pop && ({1'b0, burst_cnt} + 9'd1) >= {1'b0, burst_eff}) || ch_empty[cur_ch] || !en[cur_ch];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) bus.CH_READ[i] = pop && cur_ch == 3'(i);
    end

    always_ff @(posedge BUS_CLK) begin
        if (rst) begin
            state <= IDLE;
            cur_ch <= '0;
            fresh <= 1'b1;
            burst_cnt <= '0;
            fifo_empty <= 1'b1;
            fifo_data <= '0;
            en <= '0;
            burst <= 8'h10;
        end else begin
            if (bus.BUS_WR && bus.BUS_ADD == ABUSWIDTH'(1)) en <= bus.BUS_DATA_IN & EN_MASK;
            if (bus.BUS_WR && bus.BUS_ADD == ABUSWIDTH'(2)) burst <= bus.BUS_DATA_IN;
            if (pop) begin
                fifo_data <= {tag, ch_word[cur_ch]};
                fifo_empty <= 1'b0;
            end else if (bus.FIFO_READ) begin
                fifo_empty <= 1'b1;
            end
            if (state == IDLE) begin
                if (found) begin
                    state <= XFER;
                    cur_ch <= next_ch;
                    burst_cnt <= '0;
                    fresh <= 1'b0;
                end
            end else begin
                if (pop) burst_cnt <= burst_cnt + 8'd1;
                if (done) state <= IDLE;
            end
        end
    end

    // a clear write wins over a coinciding pop
    always_ff @(posedge BUS_CLK) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst || cnt_clr) cnt[i] <= '0;
            else if (bus.CH_READ[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
            if (rst) hi_buf[i] <= '0;
            else if (bus.BUS_RD && bus.BUS_ADD == ABUSWIDTH'(4 + 2 * i)) hi_buf[i] <= cnt[i][15:8];
        end
    end

    always_comb begin
        rd_mux = '0;
        if (bus.BUS_ADD == '0) rd_mux = VERSION;
        if (bus.BUS_ADD == ABUSWIDTH'(1)) rd_mux = en;
        if (bus.BUS_ADD == ABUSWIDTH'(2)) rd_mux = burst;
        if (bus.BUS_ADD == ABUSWIDTH'(3)) rd_mux = {fifo_empty, state == XFER, 3'b000, cur_ch};
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.BUS_ADD == ABUSWIDTH'(4 + 2 * i)) rd_mux = cnt[i][7:0];
            if (bus.BUS_ADD == ABUSWIDTH'(5 + 2 * i)) rd_mux = hi_buf[i];
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) bus.BUS_DATA_OUT <= '0;
        else if (bus.BUS_RD) bus.BUS_DATA_OUT <= rd_mux;
    end

    assign bus.FIFO_EMPTY = fifo_empty;
    assign bus.FIFO_DATA = fifo_data;
    assign bus.CUR_CH = cur_ch;
endmodule
